// File: rtl/decoder_rr_arbiter.sv
// Round-robin arbiter granting one of N requesters a shared decoded-select
// resource; owner index is registered and the grant is its one-hot decode.
module decoder_rr_arbiter #(
  parameter int SEL_W    = 3,
  parameter int MAX_HOLD = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [(1<<SEL_W)-1:0]   req,
  input  logic                    done,
  output logic [(1<<SEL_W)-1:0]   gnt,
  output logic [SEL_W-1:0]        gnt_sel,
  output logic                    gnt_valid,
  output logic                    expired
);

  localparam int N = 1 << SEL_W;
  localparam logic [7:0] MAX_HOLD_C = 8'(MAX_HOLD);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  state_t            state_r, state_n;
  logic [SEL_W-1:0]  sel_r, sel_n;
  logic [SEL_W-1:0]  ptr_r, ptr_n;
  logic [7:0]        hcnt_r, hcnt_n;
  logic              valid_r, valid_n;
  logic              expired_r, expired_n;
  logic [N-1:0]      gnt_r, gnt_n;

  logic              own_req_s;
  logic              at_limit_s;
  logic              release_s;
  logic [SEL_W-1:0]  base_s;
  logic [SEL_W:0]    search_s;

  // First requester at or after base, wrapping; result is {found, index}.
  function automatic logic [SEL_W:0] rr_search(input logic [N-1:0] r,
                                               input logic [SEL_W-1:0] base);
    logic [SEL_W:0]   res;
    logic [SEL_W-1:0] idx;
    res = '0;
    for (int k = N - 1; k >= 0; k--) begin
      idx = base + SEL_W'(k);
      if (r[idx]) begin
        res = {1'b1, idx};
      end else begin
        res = res;
      end
    end
    return res;
  endfunction

  // Next-state, owner selection and hold-counter logic.
  always_comb begin
    state_n   = state_r;
    sel_n     = sel_r;
    ptr_n     = ptr_r;
    hcnt_n    = hcnt_r;
    valid_n   = valid_r;
    expired_n = 1'b0;
    own_req_s  = req[sel_r];
    at_limit_s = (hcnt_r == MAX_HOLD_C);
    release_s  = done | ~own_req_s | at_limit_s;
    // On release the old owner gets lowest priority in this same search.
    base_s   = (state_r == BUSY) ? (sel_r + SEL_W'(1)) : ptr_r;
    search_s = rr_search(req, base_s);
    case (state_r)
      IDLE: begin
        if (|req) begin
          sel_n   = search_s[SEL_W-1:0];
          valid_n = 1'b1;
          hcnt_n  = 8'd1;
          state_n = BUSY;
        end else begin
          valid_n = 1'b0;
        end
      end
      BUSY: begin
        if (release_s) begin
          ptr_n     = sel_r + SEL_W'(1);
          expired_n = at_limit_s & ~done & own_req_s;
          if (search_s[SEL_W]) begin
            sel_n  = search_s[SEL_W-1:0];
            hcnt_n = 8'd1;
          end else begin
            valid_n = 1'b0;
            hcnt_n  = 8'd0;
            state_n = IDLE;
          end
        end else begin
          hcnt_n = at_limit_s ? hcnt_r : (hcnt_r + 8'd1);
        end
      end
      default: begin
        state_n = IDLE;
        valid_n = 1'b0;
        hcnt_n  = 8'd0;
      end
    endcase
    if (valid_n) begin
      gnt_n = {{(N-1){1'b0}}, 1'b1} << sel_n;
    end else begin
      gnt_n = '0;
    end
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= IDLE;
      sel_r     <= '0;
      ptr_r     <= '0;
      hcnt_r    <= 8'd0;
      valid_r   <= 1'b0;
      expired_r <= 1'b0;
      gnt_r     <= '0;
    end else begin
      state_r   <= state_n;
      sel_r     <= sel_n;
      ptr_r     <= ptr_n;
      hcnt_r    <= hcnt_n;
      valid_r   <= valid_n;
      expired_r <= expired_n;
      gnt_r     <= gnt_n;
    end
  end

  assign gnt       = gnt_r;
  assign gnt_sel   = sel_r;
  assign gnt_valid = valid_r;
  assign expired   = expired_r;

endmodule

// File: tb/tb_decoder_rr_arbiter.sv
// Directed, table-driven bench for decoder_rr_arbiter (MAX_HOLD=16 and MAX_HOLD=1 builds).
module tb_decoder_rr_arbiter;

  logic       clk;
  logic       rst_n;
  logic [7:0] req;
  logic       done;
  logic [7:0] gnt;
  logic [2:0] gnt_sel;
  logic       gnt_valid;
  logic       expired;

  logic [7:0] req_b;
  logic       done_b;
  logic [7:0] gnt_b;
  logic [2:0] gnt_sel_b;
  logic       gnt_valid_b;
  logic       expired_b;

  int passed;
  int total;

  decoder_rr_arbiter #(.SEL_W(3), .MAX_HOLD(16)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .done(done),
    .gnt(gnt), .gnt_sel(gnt_sel), .gnt_valid(gnt_valid), .expired(expired)
  );

  decoder_rr_arbiter #(.SEL_W(3), .MAX_HOLD(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .req(req_b), .done(done_b),
    .gnt(gnt_b), .gnt_sel(gnt_sel_b), .gnt_valid(gnt_valid_b), .expired(expired_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] req;
    logic       done;
    logic [7:0] gnt;
    logic [2:0] sel;
    logic       valid;
    logic       expired;
  } vec_t;

  vec_t vecs[25];

  task automatic chk(input string name, input logic [7:0] g, input logic [2:0] s,
                     input logic v, input logic e,
                     input logic [7:0] eg, input logic [2:0] es,
                     input logic ev, input logic ee);
    total++;
    if ({g, s, v, e} === {eg, es, ev, ee}) begin
      passed++;
    end else begin
      $display("FAIL %s: got gnt=%h sel=%0d valid=%b expired=%b, want gnt=%h sel=%0d valid=%b expired=%b",
               name, g, s, v, e, eg, es, ev, ee);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(input logic [7:0] r, input logic d, input logic [7:0] g,
                              input logic [2:0] s, input logic v, input logic e);
    vec_t x;
    x.req = r; x.done = d; x.gnt = g; x.sel = s; x.valid = v; x.expired = e;
    return x;
  endfunction

  initial begin
    passed = 0;
    total  = 0;
    rst_n  = 1'b0;
    req    = 8'h00;
    done   = 1'b0;
    req_b  = 8'h00;
    done_b = 1'b0;

    // rotation, wrap/fairness, withdrawal, idle-ignores-done, sole re-grant
    vecs[0]  = mk(8'hFF, 1'b0, 8'h01, 3'd0, 1'b1, 1'b0);
    vecs[1]  = mk(8'hFF, 1'b1, 8'h02, 3'd1, 1'b1, 1'b0);
    vecs[2]  = mk(8'hFF, 1'b1, 8'h04, 3'd2, 1'b1, 1'b0);
    vecs[3]  = mk(8'hFF, 1'b1, 8'h08, 3'd3, 1'b1, 1'b0);
    vecs[4]  = mk(8'hFF, 1'b1, 8'h10, 3'd4, 1'b1, 1'b0);
    vecs[5]  = mk(8'hFF, 1'b1, 8'h20, 3'd5, 1'b1, 1'b0);
    vecs[6]  = mk(8'hFF, 1'b1, 8'h40, 3'd6, 1'b1, 1'b0);
    vecs[7]  = mk(8'hFF, 1'b1, 8'h80, 3'd7, 1'b1, 1'b0);
    vecs[8]  = mk(8'hFF, 1'b1, 8'h01, 3'd0, 1'b1, 1'b0);
    vecs[9]  = mk(8'hFF, 1'b1, 8'h02, 3'd1, 1'b1, 1'b0);
    vecs[10] = mk(8'hFF, 1'b1, 8'h04, 3'd2, 1'b1, 1'b0);
    vecs[11] = mk(8'hFF, 1'b1, 8'h08, 3'd3, 1'b1, 1'b0);
    vecs[12] = mk(8'hFF, 1'b1, 8'h10, 3'd4, 1'b1, 1'b0);
    vecs[13] = mk(8'hFF, 1'b1, 8'h20, 3'd5, 1'b1, 1'b0);
    vecs[14] = mk(8'hFF, 1'b1, 8'h40, 3'd6, 1'b1, 1'b0);
    vecs[15] = mk(8'h41, 1'b1, 8'h01, 3'd0, 1'b1, 1'b0);
    vecs[16] = mk(8'h41, 1'b1, 8'h40, 3'd6, 1'b1, 1'b0);
    vecs[17] = mk(8'h20, 1'b0, 8'h20, 3'd5, 1'b1, 1'b0);
    vecs[18] = mk(8'h00, 1'b0, 8'h00, 3'd5, 1'b0, 1'b0);
    vecs[19] = mk(8'h08, 1'b0, 8'h08, 3'd3, 1'b1, 1'b0);
    vecs[20] = mk(8'h08, 1'b0, 8'h08, 3'd3, 1'b1, 1'b0);
    vecs[21] = mk(8'h00, 1'b1, 8'h00, 3'd3, 1'b0, 1'b0);
    vecs[22] = mk(8'h00, 1'b1, 8'h00, 3'd3, 1'b0, 1'b0);
    vecs[23] = mk(8'h10, 1'b0, 8'h10, 3'd4, 1'b1, 1'b0);
    vecs[24] = mk(8'h10, 1'b1, 8'h10, 3'd4, 1'b1, 1'b0);

    #2;
    chk("reset_state", gnt, gnt_sel, gnt_valid, expired, 8'h00, 3'd0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    // single requester holds MAX_HOLD cycles, then expires and is re-granted
    req = 8'h04;
    step();
    chk("single_first", gnt, gnt_sel, gnt_valid, expired, 8'h04, 3'd2, 1'b1, 1'b0);
    for (int i = 0; i < 15; i++) begin
      step();
      chk("single_hold", gnt, gnt_sel, gnt_valid, expired, 8'h04, 3'd2, 1'b1, 1'b0);
    end
    step();
    chk("single_expire", gnt, gnt_sel, gnt_valid, expired, 8'h04, 3'd2, 1'b1, 1'b1);
    step();
    chk("single_after", gnt, gnt_sel, gnt_valid, expired, 8'h04, 3'd2, 1'b1, 1'b0);

    rst_n = 1'b0;
    req   = 8'h00;
    #1;
    chk("reset_again", gnt, gnt_sel, gnt_valid, expired, 8'h00, 3'd0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 25; i++) begin
      req  = vecs[i].req;
      done = vecs[i].done;
      step();
      chk($sformatf("vec%0d", i), gnt, gnt_sel, gnt_valid, expired,
          vecs[i].gnt, vecs[i].sel, vecs[i].valid, vecs[i].expired);
    end

    // async reset mid-grant: owner 4 with ptr=5; restart must search from 0
    done = 1'b0;
    #3;
    rst_n = 1'b0;
    #1;
    chk("async_reset", gnt, gnt_sel, gnt_valid, expired, 8'h00, 3'd0, 1'b0, 1'b0);
    req = 8'h30;
    @(negedge clk);
    rst_n = 1'b1;
    step();
    chk("post_reset_grant", gnt, gnt_sel, gnt_valid, expired, 8'h10, 3'd4, 1'b1, 1'b0);
    req = 8'h00;

    // MAX_HOLD=1 build: pure rotation between requesters 0 and 2
    req_b = 8'h05;
    step();
    chk("mh1_c0", gnt_b, gnt_sel_b, gnt_valid_b, expired_b, 8'h01, 3'd0, 1'b1, 1'b0);
    step();
    chk("mh1_c1", gnt_b, gnt_sel_b, gnt_valid_b, expired_b, 8'h04, 3'd2, 1'b1, 1'b1);
    step();
    chk("mh1_c2", gnt_b, gnt_sel_b, gnt_valid_b, expired_b, 8'h01, 3'd0, 1'b1, 1'b1);
    step();
    chk("mh1_c3", gnt_b, gnt_sel_b, gnt_valid_b, expired_b, 8'h04, 3'd2, 1'b1, 1'b1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
